mem_req_issue: RTL and testbench

MEM_REQ_ISSUE -- requirements
Module: mem_req_issue

---
 rtl/mem_req_issue.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_req_issue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_issue.sv
// rtl/mem_req_issue.sv - memory request issue stage with in-order response queue
//
// Purpose:
//    Turns execute-stage load/store ops into bus requests and keeps a small
//    in-order queue of outstanding ops, so that bus responses can be matched
//    back to their destination tag and the load data extended correctly.
//    Misaligned ops never reach the bus. They report an alignment exception
//    once all older responses have drained. A flush cancels every
//    outstanding entry. Cancelled entries still consume their bus response,
//    but they produce no resp_valid.
//
// Ports:
//    clk, resetn                   clock, synchronous active-low reset
//    in_valid/in_ready             execute-stage op handshake
//    in_we, in_size, in_unsigned   op kind, access size (log2 bytes), zero-extend
//    in_addr, in_wdata, in_tag     address, LSB-aligned store data, destination tag
//    flush                         pipeline flush
//    req, wr, size, wstrb,
//    addr, wdata                   bus request channel
//    addr_ok                       bus accepted the request
//    data_ok, rdata                bus response for the oldest request
//    resp_valid, resp_tag,
//    resp_data, resp_ale           registered response to the pipeline
//    busy                          queue non-empty
module mem_req_issue #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 5
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_we,
   input  logic [1:0]          in_size,
   input  logic                in_unsigned,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   input  logic [TAG_W-1:0]    in_tag,
   input  logic                flush,
   output logic                req,
   output logic                wr,
   output logic [1:0]          size,
   output logic [DATA_W/8-1:0] wstrb,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W-1:0]   wdata,
   input  logic                addr_ok,
   input  logic                data_ok,
   input  logic [DATA_W-1:0]   rdata,
   output logic                resp_valid,
   output logic [TAG_W-1:0]    resp_tag,
   output logic [DATA_W-1:0]   resp_data,
   output logic                resp_ale,
   output logic                busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   // queue state
   logic [CNT_W-1:0]  count_q;
   logic [PTR_W-1:0]  wptr_q;
   logic [PTR_W-1:0]  rptr_q;
   logic [DEPTH-1:0]  cancel_q;
   logic [DEPTH-1:0]  cancel_d;
   logic [DEPTH-1:0]  live;
   logic [TAG_W-1:0]  tag_q    [DEPTH];
   logic [1:0]        size_q   [DEPTH];
   logic              uns_q    [DEPTH];
   logic              we_q     [DEPTH];
   logic [OFF_W-1:0]  off_q    [DEPTH];

   // response registers
   logic              resp_valid_q;
   logic [TAG_W-1:0]  resp_tag_q;
   logic [DATA_W-1:0] resp_data_q;
   logic              resp_ale_q;

   logic [OFF_W-1:0]  off;
   logic              ale;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              ale_take;
   logic              head_cancel;
   logic [STRB_W-1:0] mask;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] keep;
   logic              sgn;
   logic [DATA_W-1:0] ld_data;

   assign off   = in_addr[OFF_W-1:0];
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   // Alignment check. Without a 64-bit bus a dword access can never be legal.
   always_comb begin
      ale = 1'b0;
      case (in_size)
         2'd0:    ale = 1'b0;
         2'd1:    ale = in_addr[0];
         2'd2:    ale = |in_addr[1:0];
         default: ale = (DATA_W == 32) ? 1'b1 : |in_addr[2:0];
      endcase
   end

   // Only pops that the queue honours count as freeing a slot. A response
   // arriving while the queue is full frees the head slot in time for a
   // new request to issue in the same cycle.
   assign pop      = data_ok & ~empty;
   assign req      = resetn & in_valid & ~ale & ~flush & (~full | pop);
   assign push     = req & addr_ok;
   // A misaligned op waits for an empty queue so its exception cannot
   // overtake older responses.
   assign ale_take = resetn & in_valid & ale & ~flush & empty;
   assign in_ready = push | ale_take;

   assign wr   = in_we;
   assign size = in_size;
   assign addr = in_addr;
   assign busy = ~empty;

   // Store data replicated so every byte lane carries the right bytes.
   always_comb begin
      wdata = in_wdata;
      case (in_size)
         2'd0:    wdata = {STRB_W{in_wdata[7:0]}};
         2'd1:    wdata = {(STRB_W/2){in_wdata[15:0]}};
         2'd2:    wdata = {(STRB_W/4){in_wdata[31:0]}};
         default: wdata = in_wdata;
      endcase
   end

   always_comb begin
      mask = '1;
      case (in_size)
         2'd0:    mask = STRB_W'(1);
         2'd1:    mask = STRB_W'(3);
         2'd2:    mask = STRB_W'(15);
         default: mask = '1;
      endcase
      wstrb = in_we ? (mask << off) : '0;
   end

   // An entry is live when its distance from the read pointer is below count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = ({1'b0, PTR_W'(PTR_W'(i) - rptr_q)} < count_q);
      end
   end

   always_comb begin
      cancel_d = cancel_q;
      if (flush) begin
         cancel_d = cancel_q | live;
      end
      if (push) begin
         cancel_d[wptr_q] = flush;
      end
   end

   // A flush in the cycle of the pop also suppresses the head's response.
   assign head_cancel = cancel_q[rptr_q] | flush;

   // Load extraction: shift the addressed lane down, keep the access width,
   // then fill the upper bits with zero or the sign bit.
   assign shifted = rdata >> {off_q[rptr_q], 3'b000};

   always_comb begin
      keep = '1;
      sgn  = shifted[DATA_W-1];
      case (size_q[rptr_q])
         2'd0: begin
            keep = DATA_W'(64'hFF);
            sgn  = shifted[7];
         end
         2'd1: begin
            keep = DATA_W'(64'hFFFF);
            sgn  = shifted[15];
         end
         2'd2: begin
            keep = DATA_W'(64'hFFFF_FFFF);
            sgn  = shifted[31];
         end
         default: begin
            keep = '1;
            sgn  = shifted[DATA_W-1];
         end
      endcase
      ld_data = (shifted & keep) | ((~uns_q[rptr_q] & sgn) ? ~keep : '0);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q      <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         cancel_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_tag_q   <= '0;
         resp_data_q  <= '0;
         resp_ale_q   <= 1'b0;
      end else begin
         count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
         cancel_q <= cancel_d;
         if (push) begin
            wptr_q <= wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         resp_valid_q <= ale_take | (pop & ~head_cancel);
         resp_ale_q   <= ale_take;
         if (ale_take) begin
            resp_tag_q  <= in_tag;
            resp_data_q <= '0;
         end else if (pop & ~head_cancel) begin
            resp_tag_q  <= tag_q[rptr_q];
            resp_data_q <= we_q[rptr_q] ? '0 : ld_data;
         end
      end
   end

   // Entry payload needs no reset: a slot is only read after being pushed.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_q[wptr_q]  <= in_tag;
         size_q[wptr_q] <= in_size;
         uns_q[wptr_q]  <= in_unsigned;
         we_q[wptr_q]   <= in_we;
         off_q[wptr_q]  <= off;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_tag   = resp_tag_q;
   assign resp_data  = resp_data_q;
   assign resp_ale   = resp_ale_q;

endmodule

// File: tb/tb_mem_req_issue.sv
// tb/tb_mem_req_issue.sv - self-checking bench for mem_req_issue
module tb_mem_req_issue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        in_valid, in_ready, in_we, in_unsigned, flush;
   logic [1:0]  in_size, size;
   logic [31:0] in_addr, in_wdata, addr, wdata, rdata, resp_data;
   logic [4:0]  in_tag, resp_tag;
   logic        req, wr, addr_ok, data_ok, resp_valid, resp_ale, busy;
   logic [3:0]  wstrb;

   logic        in_valid_w, in_ready_w, in_we_w, in_unsigned_w, flush_w;
   logic [1:0]  in_size_w, size_w;
   logic [31:0] in_addr_w, addr_w;
   logic [63:0] in_wdata_w, wdata_w, rdata_w, resp_data_w;
   logic [4:0]  in_tag_w, resp_tag_w;
   logic        req_w, wr_w, addr_ok_w, data_ok_w, resp_valid_w, resp_ale_w, busy_w;
   logic [7:0]  wstrb_w;

   mem_req_issue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TAG_W(5)) u_dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_we(in_we), .in_size(in_size), .in_unsigned(in_unsigned),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag), .flush(flush),
      .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
      .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
      .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
      .resp_ale(resp_ale), .busy(busy)
   );

   mem_req_issue #(.ADDR_W(32), .DATA_W(64), .DEPTH(4), .TAG_W(5)) u_dut64 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid_w), .in_ready(in_ready_w),
      .in_we(in_we_w), .in_size(in_size_w), .in_unsigned(in_unsigned_w),
      .in_addr(in_addr_w), .in_wdata(in_wdata_w), .in_tag(in_tag_w), .flush(flush_w),
      .req(req_w), .wr(wr_w), .size(size_w), .wstrb(wstrb_w), .addr(addr_w),
      .wdata(wdata_w), .addr_ok(addr_ok_w), .data_ok(data_ok_w), .rdata(rdata_w),
      .resp_valid(resp_valid_w), .resp_tag(resp_tag_w), .resp_data(resp_data_w),
      .resp_ale(resp_ale_w), .busy(busy_w)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", t, got, exp);
      end
   endtask

   typedef struct {
      logic [4:0] tag;
      logic       we;
      logic [1:0] sz;
      logic       uns;
      logic [1:0] off;
      logic       cancelled;
   } op_t;

   op_t  q[$];
   logic obs_req, obs_rdy;

   function automatic logic [31:0] ext_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
      int          nb;
      logic [63:0] v;
      logic [63:0] m;
      nb = 1 << sz;
      v  = {32'h0, rd} >> (8 * off);
      m  = (64'd1 << (8 * nb)) - 64'd1;
      v  = v & m;
      if (!uns && v[8*nb-1]) v = v | ~m;
      return v[31:0];
   endfunction

   // One bus cycle on the 32-bit instance, checked against the queue model.
   task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg,
                       input logic fl, input logic aok, input logic dok, input logic [31:0] rd);
      logic        mis, e_req, e_take, e_pop, e_rv, e_ale;
      logic [4:0]  e_tag;
      logic [31:0] e_data, e_wdata;
      logic [7:0]  ms;
      logic [3:0]  e_wstrb;
      op_t         h;
      @(negedge clk);
      in_valid = v; in_we = we; in_size = sz; in_unsigned = uns; in_addr = a;
      in_wdata = wd; in_tag = tg; flush = fl; addr_ok = aok; data_ok = dok; rdata = rd;
      #2;
      mis    = (sz == 2'd3) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
      e_pop  = dok && (q.size() > 0);
      e_req  = v && !mis && !fl && ((q.size() < 4) || e_pop);
      e_take = v && mis && !fl && (q.size() == 0);
      obs_req = req;
      obs_rdy = in_ready;
      chk("req", req, e_req);
      chk("in_ready", in_ready, (e_req && aok) || e_take);
      chk("wr", wr, we);
      chk("size", size, sz);
      chk("addr", addr, a);
      chk("busy", busy, q.size() != 0);
      if (sz != 2'd3) begin
         case (sz)
            2'd0:    e_wdata = {4{wd[7:0]}};
            2'd1:    e_wdata = {2{wd[15:0]}};
            default: e_wdata = wd;
         endcase
         ms      = ((8'd1 << (4'd1 << sz)) - 8'd1) << a[1:0];
         e_wstrb = we ? ms[3:0] : 4'h0;
         chk("wdata", wdata, e_wdata);
         chk("wstrb", wstrb, e_wstrb);
      end
      e_rv = 1'b0; e_ale = 1'b0; e_tag = 5'h0; e_data = 32'h0;
      if (fl) begin
         foreach (q[i]) q[i].cancelled = 1'b1;
      end
      if (e_pop) begin
         h = q.pop_front();
         if (!h.cancelled) begin
            e_rv   = 1'b1;
            e_tag  = h.tag;
            e_data = h.we ? 32'h0 : ext_load(rd, h.sz, h.uns, h.off);
         end
      end
      if (e_req && aok) q.push_back('{tg, we, sz, uns, a[1:0], fl});
      if (e_take) begin
         e_rv = 1'b1; e_ale = 1'b1; e_tag = tg; e_data = 32'h0;
      end
      @(posedge clk);
      #1;
      chk("resp_valid", resp_valid, e_rv);
      if (e_rv) begin
         chk("resp_tag", resp_tag, e_tag);
         chk("resp_data", resp_data, e_data);
         chk("resp_ale", resp_ale, e_ale);
      end
   endtask

   task automatic idle(input int n, input logic dok);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, dok, 32'h5A5A_5A5A);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b0;
      in_valid = 1'b1; in_we = 1'b0; in_size = 2'd2; in_addr = 32'h100; flush = 1'b0;
      addr_ok = 1'b1; data_ok = 1'b0;
      #2;
      chk("rst_req", req, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_tag", resp_tag, 5'h0);
      chk("rst_resp_data", resp_data, 32'h0);
      chk("rst_resp_ale", resp_ale, 1'b0);
      chk("rst_busy", busy, 1'b0);
      q.delete();
      @(negedge clk);
      resetn = 1'b1;
      in_valid = 1'b0;
   endtask

   logic [1:0]  rs;
   logic [31:0] ra;

   initial begin
      resetn = 1'b0;
      in_valid = 0; in_we = 0; in_size = 0; in_unsigned = 0; in_addr = 0; in_wdata = 0;
      in_tag = 0; flush = 0; addr_ok = 0; data_ok = 0; rdata = 0;
      in_valid_w = 0; in_we_w = 0; in_size_w = 0; in_unsigned_w = 0; in_addr_w = 0;
      in_wdata_w = 0; in_tag_w = 0; flush_w = 0; addr_ok_w = 0; data_ok_w = 0; rdata_w = 0;
      repeat (2) @(posedge clk);
      apply_reset();

      // signed half load at 0x1002
      step(1'b1, 1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("t25_wstrb", wstrb, 4'h0);
      chk("t25_size", size, 2'd1);
      step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8001_0000);
      chk("t25_data", resp_data, 32'hFFFF_8001);

      // byte store at 0x1003
      step(1'b1, 1'b1, 2'd0, 1'b0, 32'h1003, 32'hAB, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("t26_wdata", wdata, 32'hABAB_ABAB);
      chk("t26_wstrb", wstrb, 4'b1000);
      step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      chk("t26_valid", resp_valid, 1'b1);
      chk("t26_data", resp_data, 32'h0);

      // fill the queue, the fifth load waits until a response frees a slot
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 2'd2, 1'b0, 32'h2000 + 32'(4*i), 32'h0, 5'(10+i), 1'b0, 1'b1, 1'b0, 32'h0);
      chk("t27_req5", obs_req, 1'b0);
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h2010, 32'h0, 5'd14, 1'b0, 1'b1, 1'b1, 32'h1111_2222);
      chk("t27_req_bypass", obs_req, 1'b1);
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h2014, 32'h0, 5'd15, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("t27_still_full", obs_req, 1'b0);
      idle(4, 1'b1);

      // misaligned word waits behind two outstanding loads
      step(1'b1, 1'b0, 2'd0, 1'b1, 32'h3001, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 2'd1, 1'b1, 32'h3002, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001, 32'h0, 5'd9, 1'b0, 1'b1, 1'(i != 0), 32'hCAFE_F00D);
         chk("t28_held", obs_rdy, 1'b0);
         chk("t28_noreq", obs_req, 1'b0);
      end
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("t28_taken", obs_rdy, 1'b1);
      chk("t28_ale", resp_ale, 1'b1);
      chk("t28_tag", resp_tag, 5'd9);

      // flush cancels three outstanding loads
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000 + 32'(4*i), 32'h0, 5'(20+i), 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
         chk("t29_cancel", resp_valid, 1'b0);
      end
      step(1'b1, 1'b0, 2'd0, 1'b1, 32'h4001, 32'h0, 5'd30, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_9900);
      chk("t29_after", resp_data, 32'h99);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         rs = 2'($urandom_range(0, 3));
         ra = {16'h0, 16'($urandom)};
         step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), rs,
              1'($urandom_range(0, 1)), ra, $urandom, 5'($urandom),
              1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 9) < 4), $urandom);
      end

      // reset with entries outstanding drops them
      idle(6, 1'b1);
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h5004, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 32'h0);
      apply_reset();
      idle(2, 1'b1);
      chk("t23_dropped", resp_valid, 1'b0);

      // 64-bit instance
      @(negedge clk);
      in_valid_w = 1'b1; in_we_w = 1'b0; in_size_w = 2'd3; in_addr_w = 32'h10;
      in_tag_w = 5'd7; addr_ok_w = 1'b1; in_unsigned_w = 1'b0;
      #2;
      chk("w_req", req_w, 1'b1);
      chk("w_size", size_w, 2'd3);
      chk("w_wstrb", wstrb_w, 8'h00);
      chk("w_ready", in_ready_w, 1'b1);
      @(negedge clk);
      in_valid_w = 1'b0; data_ok_w = 1'b1; rdata_w = 64'h8123_4567_89AB_CDEF;
      @(posedge clk);
      #1;
      chk("w_valid", resp_valid_w, 1'b1);
      chk("w_data", resp_data_w, 64'h8123_4567_89AB_CDEF);
      chk("w_tag", resp_tag_w, 5'd7);
      @(negedge clk);
      data_ok_w = 1'b0; in_valid_w = 1'b1; in_addr_w = 32'h14; in_tag_w = 5'd8;
      #2;
      chk("w_mis_req", req_w, 1'b0);
      chk("w_mis_ready", in_ready_w, 1'b1);
      @(posedge clk);
      #1;
      chk("w_mis_valid", resp_valid_w, 1'b1);
      chk("w_mis_ale", resp_ale_w, 1'b1);
      chk("w_mis_data", resp_data_w, 64'h0);
      @(negedge clk);
      in_we_w = 1'b1; in_size_w = 2'd0; in_addr_w = 32'h15; in_wdata_w = 64'h5C;
      #2;
      chk("w_strb_byte", wstrb_w, 8'h20);
      chk("w_wdata_byte", wdata_w, 64'h5C5C_5C5C_5C5C_5C5C);
      in_we_w = 1'b0; in_size_w = 2'd2; in_addr_w = 32'h14; in_tag_w = 5'd9;
      @(posedge clk);
      @(negedge clk);
      in_valid_w = 1'b0; data_ok_w = 1'b1; rdata_w = 64'h9000_0001_0000_0000;
      data_ok_w = 1'b1;
      @(posedge clk);
      #1;
      chk("w_word_hi", resp_data_w, 64'hFFFF_FFFF_9000_0001);
      @(negedge clk);
      data_ok_w = 1'b0;
      @(posedge clk);
      #1;
      chk("w_busy", busy_w, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
